// File: rtl/dbg_uart_host.sv
// Debug UART host: assembles 9-byte command frames from the UART receiver, issues them
// to the core debug port and returns the 32-bit result as 4 bytes, LSB first.
//
// state    | meaning
// ST_RX    | collecting frame bytes (a leading 0x00 is a resync/NOP)
// ST_ISSUE | command held on the debug port until ready or timeout
// ST_RESP  | streaming the 4 response bytes to the transmitter
module dbg_uart_host #(
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] TIMEOUT_WORD   = 32'hDEADBEEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic [7:0]  dbg_cmd_o,
   output logic [31:0] dbg_addr_o,
   output logic [31:0] dbg_data_o,
   input  logic [31:0] dbg_data_i,
   input  logic        dbg_ready_i,
   output logic        overrun_o,
   output logic        timeout_o,
   input  logic        clr_i
);

   typedef enum logic [1:0] {ST_RX, ST_ISSUE, ST_RESP} state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  byte_cnt;
   logic [15:0] tmr;
   logic [1:0]  tx_idx;
   logic [7:0]  cmd;
   logic [31:0] resp;
   logic        rx_take, last_byte, ready_hit, tmo_hit, tx_fire;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= ST_RX;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rx_take   = 1'b0;
      last_byte = 1'b0;
      ready_hit = 1'b0;
      tmo_hit   = 1'b0;
      tx_fire   = 1'b0;
      case (state)
         ST_RX: begin
            rx_take   = rx_valid_i && !(byte_cnt == 4'd0 && rx_data_i == 8'h00);
            last_byte = rx_take && (byte_cnt == 4'd8);
            if (last_byte) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            // ready beats a timeout landing in the same cycle
            ready_hit = dbg_ready_i;
            tmo_hit   = !dbg_ready_i && (tmr == TMO_LAST);
            if (ready_hit || tmo_hit) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            tx_fire = tx_ready_i;
            if (tx_fire && tx_idx == 2'd3) state_nxt = ST_RX;
         end
         default: state_nxt = ST_RX;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         byte_cnt   <= 4'd0;
         tmr        <= 16'd0;
         tx_idx     <= 2'd0;
         cmd        <= 8'h00;
         resp       <= 32'h0;
         dbg_addr_o <= 32'h0;
         dbg_data_o <= 32'h0;
         overrun_o  <= 1'b0;
         timeout_o  <= 1'b0;
      end else begin
         if (rx_take) begin
            byte_cnt <= last_byte ? 4'd0 : byte_cnt + 4'd1;
            // little-endian fields: shift each byte in from the top
            if (byte_cnt == 4'd0)
               cmd <= rx_data_i;
            else if (byte_cnt <= 4'd4)
               dbg_addr_o <= {rx_data_i, dbg_addr_o[31:8]};
            else
               dbg_data_o <= {rx_data_i, dbg_data_o[31:8]};
         end
         tmr <= (state == ST_ISSUE) ? tmr + 16'd1 : 16'd0;
         if (ready_hit)    resp <= dbg_data_i;
         else if (tmo_hit) resp <= TIMEOUT_WORD;
         if (tx_fire) tx_idx <= tx_idx + 2'd1;
         overrun_o <= (rx_valid_i && state != ST_RX) || (overrun_o && !clr_i);
         timeout_o <= tmo_hit || (timeout_o && !clr_i);
      end
   end

   assign dbg_cmd_o  = (state == ST_ISSUE) ? cmd : 8'h00;
   assign tx_valid_o = (state == ST_RESP);
   assign tx_data_o  = tx_valid_o ? resp[{tx_idx, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_dbg_uart_host.sv
// Bench for dbg_uart_host: transaction-level model (frame/response queues) checked every
// cycle, plus literal expectations for the reference scenarios.
module tb_dbg_uart_host;
   localparam int          TMO = 8;
   localparam logic [31:0] TW  = 32'hDEADBEEF;

   logic        clk = 1'b0, rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic [7:0]  dbg_cmd;
   logic [31:0] dbg_addr, dbg_wdata;
   logic [31:0] dbg_rdata = 32'h0;
   logic        dbg_ready = 1'b0;
   logic        overrun, timeout;
   logic        clr = 1'b0;

   int n_checks = 0, n_fail = 0;
   int cmd_cyc = 0, n_issue = 0;
   logic [7:0] prev_cmd = 8'h00;
   logic [7:0] txlog[$];

   // model state
   logic [7:0]  m_frame[$];
   logic [7:0]  m_resp[$];
   bit          m_issuing = 0;
   int          m_age = 0;
   logic [7:0]  m_cmd = 8'h00;
   logic [31:0] m_addr = 32'h0, m_data = 32'h0;
   bit          m_ovr = 0, m_tmo = 0;

   dbg_uart_host #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_WORD(TW)) dut (
      .clk_i(clk), .rst_i(rst),
      .rx_data_i(rx_data), .rx_valid_i(rx_valid),
      .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
      .dbg_cmd_o(dbg_cmd), .dbg_addr_o(dbg_addr), .dbg_data_o(dbg_wdata),
      .dbg_data_i(dbg_rdata), .dbg_ready_i(dbg_ready),
      .overrun_o(overrun), .timeout_o(timeout), .clr_i(clr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void push_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) m_resp.push_back(w[8*i +: 8]);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_frame.delete();
         m_resp.delete();
         m_issuing = 0;
         m_age = 0;
         m_ovr = 0;
         m_tmo = 0;
      end else begin
         bit ovr_set, tmo_set;
         ovr_set = 0;
         tmo_set = 0;
         if (m_resp.size() > 0) begin
            if (rx_valid) ovr_set = 1;
            if (tx_ready) void'(m_resp.pop_front());
         end else if (m_issuing) begin
            if (rx_valid) ovr_set = 1;
            if (dbg_ready) begin
               push_word(dbg_rdata);
               m_issuing = 0;
            end else begin
               m_age++;
               if (m_age == TMO) begin
                  push_word(TW);
                  tmo_set = 1;
                  m_issuing = 0;
               end
            end
         end else if (rx_valid && !(m_frame.size() == 0 && rx_data == 8'h00)) begin
            m_frame.push_back(rx_data);
            if (m_frame.size() == 9) begin
               m_cmd  = m_frame[0];
               m_addr = {m_frame[4], m_frame[3], m_frame[2], m_frame[1]};
               m_data = {m_frame[8], m_frame[7], m_frame[6], m_frame[5]};
               m_issuing = 1;
               m_age = 0;
               m_frame.delete();
            end
         end
         m_ovr = ovr_set || (m_ovr && !clr);
         m_tmo = tmo_set || (m_tmo && !clr);
      end
   end

   always @(posedge clk)
      if (!rst && tx_valid && tx_ready) txlog.push_back(tx_data);

   always @(negedge clk) begin
      chk("m_dbg_cmd", 32'(dbg_cmd), m_issuing ? 32'(m_cmd) : 32'h0);
      if (m_issuing) begin
         chk("m_dbg_addr", dbg_addr, m_addr);
         chk("m_dbg_data", dbg_wdata, m_data);
      end
      chk("m_tx_valid", 32'(tx_valid), (m_resp.size() > 0) ? 32'h1 : 32'h0);
      if (m_resp.size() > 0) chk("m_tx_data", 32'(tx_data), 32'(m_resp[0]));
      chk("m_overrun", 32'(overrun), 32'(m_ovr));
      chk("m_timeout", 32'(timeout), 32'(m_tmo));
      if (dbg_cmd != 8'h00) cmd_cyc++;
      if (dbg_cmd != 8'h00 && prev_cmd == 8'h00) n_issue++;
      prev_cmd = dbg_cmd;
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data = 8'h00;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
      send_byte(c);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
   endtask

   task automatic ready_pulse(input logic [31:0] d);
      dbg_rdata = d;
      dbg_ready = 1'b1;
      @(negedge clk);
      dbg_ready = 1'b0;
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic check_tx(input string nm, input logic [31:0] w);
      int k = 0;
      while (txlog.size() < 4 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_count"}, 32'(txlog.size()), 32'd4);
      if (txlog.size() >= 4) chk(nm, {txlog[3], txlog[2], txlog[1], txlog[0]}, w);
      txlog.delete();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_cmd", 32'(dbg_cmd), 32'h0);
      chk("rst_addr", dbg_addr, 32'h0);
      chk("rst_tx_valid", 32'(tx_valid), 32'h0);
      chk("rst_tx_data", 32'(tx_data), 32'h0);
      chk("rst_flags", {30'h0, overrun, timeout}, 32'h0);
      rst = 1'b0;

      // basic command, plus a byte arriving mid-command
      send_frame(8'h01, 32'h10000000, 32'hDEADBEEF);
      chk("t1_cmd", 32'(dbg_cmd), 32'h01);
      chk("t1_addr", dbg_addr, 32'h10000000);
      chk("t1_data", dbg_wdata, 32'hDEADBEEF);
      send_byte(8'h55);
      repeat (2) @(negedge clk);
      chk("t1_cmd_held", 32'(dbg_cmd), 32'h01);
      chk("t1_overrun", 32'(overrun), 32'h1);
      ready_pulse(32'h12345678);
      chk("t1_cmd_drop", 32'(dbg_cmd), 32'h0);
      clr_pulse();
      check_tx("t1_resp", 32'h12345678);
      chk("t1_overrun_clr", 32'(overrun), 32'h0);

      // leading zeros ignored, zero bytes inside the frame kept
      send_byte(8'h00);
      send_byte(8'h00);
      send_frame(8'h02, 32'h00000000, 32'hCAFEF00D);
      chk("t2_cmd", 32'(dbg_cmd), 32'h02);
      chk("t2_data", dbg_wdata, 32'hCAFEF00D);
      @(negedge clk);
      ready_pulse(32'hA5A50F0F);
      check_tx("t2_resp", 32'hA5A50F0F);
      chk("t2_issues", 32'(n_issue), 32'd2);

      // timeout
      cmd_cyc = 0;
      send_frame(8'h03, 32'h00000020, 32'h00000030);
      check_tx("t3_resp", TW);
      chk("t3_cmd_cycles", 32'(cmd_cyc), 32'd8);
      chk("t3_timeout", 32'(timeout), 32'h1);
      clr_pulse();
      chk("t3_timeout_clr", 32'(timeout), 32'h0);

      // overrun during a stalled response
      tx_ready = 1'b0;
      send_frame(8'h04, 32'h00000040, 32'h00000050);
      ready_pulse(32'h11223344);
      for (int i = 0; i < 20; i++) begin
         rx_valid = (i == 5);
         rx_data = (i == 5) ? 8'h77 : 8'h00;
         @(negedge clk);
         chk("t4_tx_hold", 32'(tx_data), 32'h44);
      end
      rx_valid = 1'b0;
      chk("t4_overrun", 32'(overrun), 32'h1);
      rx_valid = 1'b1;
      clr = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      clr = 1'b0;
      chk("t4_set_wins", 32'(overrun), 32'h1);
      clr_pulse();
      chk("t4_overrun_clr", 32'(overrun), 32'h0);
      tx_ready = 1'b1;
      check_tx("t4_resp", 32'h11223344);

      // ready on the exact timeout cycle
      send_frame(8'h05, 32'h00000060, 32'h00000070);
      repeat (7) @(negedge clk);
      ready_pulse(32'h0BADF00D);
      check_tx("t5_resp", 32'h0BADF00D);
      chk("t5_timeout", 32'(timeout), 32'h0);

      // reset mid-frame
      send_byte(8'h06);
      for (int i = 0; i < 4; i++) send_byte(8'h11);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_cmd", 32'(dbg_cmd), 32'h0);
      chk("t6_rst_addr", dbg_addr, 32'h0);
      chk("t6_rst_tx", {23'h0, tx_valid, tx_data}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_no_reissue", 32'(dbg_cmd), 32'h0);
      send_frame(8'h07, 32'hA0B0C0D0, 32'h01020304);
      chk("t6_cmd", 32'(dbg_cmd), 32'h07);
      chk("t6_addr", dbg_addr, 32'hA0B0C0D0);
      chk("t6_data", dbg_wdata, 32'h01020304);
      ready_pulse(32'h55AA55AA);
      check_tx("t6_resp", 32'h55AA55AA);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/dbg_uart_host.md
DBG_UART_HOST -- requirements
Module: dbg_uart_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning max cycles a debug command is held before abort (range 2..65535).
REQ-002 SHALL have parameter TIMEOUT_WORD, default 32'hDEADBEEF, meaning response word returned on timeout.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port rx_data_i  input  8  received byte from UART receiver.
REQ-006 SHALL have port rx_valid_i  input  1  one-cycle strobe, rx_data_i valid; no backpressure.
REQ-007 SHALL have port tx_data_o  output  8  byte to UART transmitter.
REQ-008 SHALL have port tx_valid_o  output  1  tx_data_o valid.
REQ-009 SHALL have port tx_ready_i  input  1  transmitter accepts byte when tx_valid_o & tx_ready_i.
REQ-010 SHALL have port dbg_cmd_o  output  8  debug command to core debug port; 0 = no command.
REQ-011 SHALL have port dbg_addr_o  output  32  debug address.
REQ-012 SHALL have port dbg_data_o  output  32  debug write data.
REQ-013 SHALL have port dbg_data_i  input  32  debug read data, sampled when dbg_ready_i high.
REQ-014 SHALL have port dbg_ready_i  input  1  debug port completion.
REQ-015 SHALL have port overrun_o  output  1  sticky: byte dropped while busy.
REQ-016 SHALL have port timeout_o  output  1  sticky: command aborted by timeout.
REQ-017 SHALL have port clr_i  input  1  synchronous clear of overrun_o and timeout_o.

Function
REQ-018 SHALL implement FSM states RX, ISSUE, RESP.
REQ-019 Frame SHALL be 9 bytes: cmd, addr[7:0..31:24], data[7:0..31:24] (little-endian), collected in RX with a 4-bit byte counter.
REQ-020 In RX, first byte equal 0x00 SHALL be discarded (resync/NOP), counter stays 0, no response.
REQ-021 On 9th byte accepted, SHALL enter ISSUE next cycle with dbg_cmd_o/addr/data driven from assembled frame.
REQ-022 In ISSUE, dbg_cmd_o/addr/data SHALL remain stable until the cycle dbg_ready_i is sampled high (inclusive).
REQ-023 On dbg_ready_i high in ISSUE, SHALL latch dbg_data_i, drive dbg_cmd_o = 0 next cycle, enter RESP.
REQ-024 Timeout counter SHALL start at 0 on entry to ISSUE, increment each cycle; at TIMEOUT_CYCLES-1 without dbg_ready_i, SHALL latch TIMEOUT_WORD, set timeout_o, dbg_cmd_o = 0, enter RESP.
REQ-025 dbg_ready_i and timeout in the same cycle: ready SHALL win (real data, timeout_o unchanged).
REQ-026 dbg_ready_i while not in ISSUE SHALL be ignored.
REQ-027 RESP SHALL send 4 bytes, LSB first, tx_valid_o high with stable tx_data_o until handshake; byte advances only on tx_valid_o & tx_ready_i.
REQ-028 After 4th handshake, SHALL return to RX with counter 0 the next cycle; no idle cycle required before next frame byte.
REQ-029 rx_valid_i in ISSUE or RESP SHALL drop the byte and set overrun_o.
REQ-030 clr_i SHALL clear flags; set event in same cycle as clr_i SHALL win (flag stays 1).
REQ-031 Response bytes SHALL be sent for every issued command regardless of command type.

Reset
REQ-032 rst_i SHALL asynchronously force: state RX, counters 0, dbg_cmd_o/addr/data 0, tx_valid_o 0, tx_data_o 0, overrun_o 0, timeout_o 0.
REQ-033 Reset mid-frame or mid-command SHALL discard partial frame/response; no command reissued after deassertion.

Verification
REQ-034 Bytes 01 00 00 00 10 EF BE AD DE -> dbg_cmd_o=01, addr 10000000, data DEADBEEF held until dbg_ready_i; dbg_data_i=12345678 -> tx bytes 78 56 34 12.
REQ-035 00 00 02 + 8 bytes -> leading zeros ignored, single command 02 issued, one 4-byte response.
REQ-036 TIMEOUT_CYCLES=8, dbg_ready_i never high -> dbg_cmd_o drops after 8 cycles, timeout_o=1, tx bytes EF BE AD DE.
REQ-037 rx_valid_i pulsed during RESP with tx_ready_i=0 for 20 cycles -> byte dropped, overrun_o=1, tx_data_o stable; clr_i -> overrun_o=0.
REQ-038 rst_i asserted after 5 frame bytes -> all outputs 0; subsequent full 9-byte frame decoded from byte 0.
REQ-039 dbg_ready_i on exact timeout cycle -> real data returned, timeout_o=0.
